// File: rtl/reset_release_sequencer_pkg.sv
// Shared types and width helpers for the reset release sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD,
    WAIT_READY,
    DONE,
    ERROR
  } seq_state_t;

  // Width of the reported failing-stage index; also wide enough for the
  // internal stage index at the maximum of 16 stages.
  localparam int ERR_IDX_W = 4;
  localparam int MAX_STAGES = 16;

  // Counter width able to hold the value 'terminal' (never below 1 bit).
  function automatic int cnt_width(input int terminal);
    return (terminal < 1) ? 1 : $clog2(terminal + 1);
  endfunction

  // Widths for the default parameter set.
  localparam int HOLD_CNT_W_DEF = cnt_width(16);
  localparam int TCNT_W_DEF     = cnt_width(255);

endpackage

// File: rtl/reset_release_sequencer_if.sv
// Stage-side reset handshake bundle: per-stage resets out, ready acks back, plus status.
// Latency: n/a (wires only).
// Backpressure: none; stage_ready is a level acknowledge, not a flow-control signal.
//   stage_rst   : sequencer -> stages, active-high reset per stage
//   stage_ready : stages -> sequencer, per-stage ready level
//   seq_done / seq_error / error_stage : sequencer status
interface reset_release_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  import reset_seq_pkg::*;

  logic [NUM_STAGES-1:0] stage_rst;
  logic [NUM_STAGES-1:0] stage_ready;
  logic                  seq_done;
  logic                  seq_error;
  logic [ERR_IDX_W-1:0]  error_stage;

  modport master (
    output stage_rst,
    output seq_done,
    output seq_error,
    output error_stage,
    input  stage_ready
  );

  modport slave (
    input  stage_rst,
    input  seq_done,
    input  seq_error,
    input  error_stage,
    output stage_ready
  );

endinterface

// File: rtl/reset_release_sequencer_hold_filter.sv
// Counts consecutive low cycles of the reset request; flags when HOLD_CYCLES is reached.
// Latency: hold_done is combinational on the cycle whose edge completes the count.
// Backpressure: none; clear restarts the count from zero on the next edge.
//   clock, reset : block clock and synchronous active-high reset
//   clear        : synchronous clear of the low-cycle count
//   count_en     : request sampled low while waiting to release
//   hold_done    : one-cycle pulse, count complete on this edge
module reset_hold_filter
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic hold_done
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] hold_cnt;

  // The edge that sees hold_cnt at TERM with the request still low is the
  // HOLD_CYCLES-th consecutive low sample.
  assign hold_done = count_en && (hold_cnt == TERM);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      hold_cnt <= '0;
    end else if (count_en && (hold_cnt != TERM)) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reset_release_sequencer.sv
// Releases downstream stage resets in order, each gated on the previous stage's ready.
// Latency: HOLD_CYCLES edges to release stage 0, then one edge per ready; outputs registered.
// Backpressure: a missing ready stalls the sequence up to TIMEOUT_CYCLES, then ERROR.
//   clock, reset : block clock and synchronous active-high reset
//   rst_req_in   : delayed reset request, 1 holds every stage in reset
//   bus          : stage_rst / stage_ready handshake and seq_done / seq_error / error_stage
module reset_release_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rst_req_in,
  reset_release_sequencer_if.master bus
);

  localparam int TCNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TCNT_W-1:0] TCNT_TERM = TCNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_t            state_q, state_n;
  logic [ERR_IDX_W-1:0]  idx_q, idx_n;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_n;
  logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_n;
  logic                  seq_done_q, seq_done_n;
  logic                  seq_error_q, seq_error_n;
  logic [ERR_IDX_W-1:0]  error_stage_q, error_stage_n;

  logic                  hold_done;
  logic                  rdy_sel;
  logic                  ready_lost;
  logic [ERR_IDX_W-1:0]  lost_idx;

  // The low-cycle count only runs while idle in HOLD; leaving HOLD clears
  // it so a later restart always counts from zero.
  reset_hold_filter #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_filter (
    .clock     (clock),
    .reset     (reset),
    .clear     (rst_req_in || (state_q != HOLD)),
    .count_en  ((state_q == HOLD) && !rst_req_in),
    .hold_done (hold_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= HOLD;
      idx_q         <= '0;
      tcnt_q        <= '0;
      stage_rst_q   <= '1;
      seq_done_q    <= 1'b0;
      seq_error_q   <= 1'b0;
      error_stage_q <= '0;
    end else begin
      state_q       <= state_n;
      idx_q         <= idx_n;
      tcnt_q        <= tcnt_n;
      stage_rst_q   <= stage_rst_n;
      seq_done_q    <= seq_done_n;
      seq_error_q   <= seq_error_n;
      error_stage_q <= error_stage_n;
    end
  end

  always_comb begin
    state_n       = state_q;
    idx_n         = idx_q;
    tcnt_n        = tcnt_q;
    stage_rst_n   = stage_rst_q;
    seq_done_n    = seq_done_q;
    seq_error_n   = seq_error_q;
    error_stage_n = error_stage_q;

    // Ready of the stage currently being waited on; unreleased stages are ignored.
    rdy_sel = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (i == int'(idx_q)) rdy_sel = bus.stage_ready[i];
    end

    // Lowest stage that has dropped ready; scanning downward lets the lowest win.
    ready_lost = 1'b0;
    lost_idx   = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!bus.stage_ready[i]) begin
        ready_lost = 1'b1;
        lost_idx   = ERR_IDX_W'(i);
      end
    end

    if (rst_req_in) begin
      // A request forces everything back to reset, including out of ERROR.
      state_n       = HOLD;
      idx_n         = '0;
      tcnt_n        = '0;
      stage_rst_n   = '1;
      seq_done_n    = 1'b0;
      seq_error_n   = 1'b0;
      error_stage_n = '0;
    end else begin
      unique case (state_q)
        HOLD: begin
          stage_rst_n = '1;
          if (hold_done) begin
            stage_rst_n[0] = 1'b0;
            idx_n          = '0;
            tcnt_n         = '0;
            state_n        = WAIT_READY;
          end
        end

        WAIT_READY: begin
          // Ready is checked before the timeout so a same-edge ready wins.
          if (rdy_sel) begin
            if (int'(idx_q) == NUM_STAGES - 1) begin
              seq_done_n = 1'b1;
              state_n    = DONE;
            end else begin
              for (int i = 0; i < NUM_STAGES; i++) begin
                if (i == int'(idx_q) + 1) stage_rst_n[i] = 1'b0;
              end
              idx_n  = idx_q + ERR_IDX_W'(1);
              tcnt_n = '0;
            end
          end else if (tcnt_q == TCNT_TERM) begin
            state_n       = ERROR;
            stage_rst_n   = '1;
            seq_error_n   = 1'b1;
            error_stage_n = idx_q;
          end else begin
            tcnt_n = tcnt_q + TCNT_W'(1);
          end
        end

        DONE: begin
          if (ready_lost) begin
            state_n       = ERROR;
            stage_rst_n   = '1;
            seq_done_n    = 1'b0;
            seq_error_n   = 1'b1;
            error_stage_n = lost_idx;
          end
        end

        ERROR: begin
          // Latched until a new reset request arrives.
          stage_rst_n = '1;
          seq_done_n  = 1'b0;
          seq_error_n = 1'b1;
        end

        default: begin
          state_n     = HOLD;
          stage_rst_n = '1;
        end
      endcase
    end
  end

  assign bus.stage_rst   = stage_rst_q;
  assign bus.seq_done    = seq_done_q;
  assign bus.seq_error   = seq_error_q;
  assign bus.error_stage = error_stage_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Directed bench for reset_release_sequencer with NUM_STAGES=4, HOLD_CYCLES=4, TIMEOUT_CYCLES=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-computed per edge.
module tb_reset_release_sequencer;

  logic clock = 1'b0;
  logic reset;
  logic rst_req_in;

  int n_vec  = 0;
  int n_miss = 0;

  reset_release_sequencer_if #(.NUM_STAGES(4)) bus();

  reset_release_sequencer #(
    .NUM_STAGES     (4),
    .HOLD_CYCLES    (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rst_req_in (rst_req_in),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] rst, input logic done,
                           input logic err, input logic [3:0] estage);
    check_vec({tag, ".stage_rst"},   32'(bus.stage_rst),   32'(rst));
    check_vec({tag, ".seq_done"},    32'(bus.seq_done),    32'(done));
    check_vec({tag, ".seq_error"},   32'(bus.seq_error),   32'(err));
    check_vec({tag, ".error_stage"}, 32'(bus.error_stage), 32'(estage));
  endtask

  initial begin
    reset           = 1'b1;
    rst_req_in      = 1'b0;
    bus.stage_ready = 4'b0000;
    step(2);
    check_all("reset_state", 4'b1111, 1'b0, 1'b0, 4'd0);

    // Request held high keeps everything in reset.
    reset      = 1'b0;
    rst_req_in = 1'b1;
    step(10);
    check_all("req_high", 4'b1111, 1'b0, 1'b0, 4'd0);

    // Normal release, each ready arriving 2 edges after its release.
    rst_req_in = 1'b0;
    step(3);
    check_vec("rel.edge3", 32'(bus.stage_rst), 32'hF);
    step(1);
    check_vec("rel.edge4", 32'(bus.stage_rst), 32'hE);
    step(1);
    check_vec("rel.edge5", 32'(bus.stage_rst), 32'hE);
    bus.stage_ready = 4'b0001;
    step(1);
    check_vec("rel.edge6", 32'(bus.stage_rst), 32'hC);
    step(1);
    bus.stage_ready = 4'b0011;
    step(1);
    check_vec("rel.edge8", 32'(bus.stage_rst), 32'h8);
    step(1);
    bus.stage_ready = 4'b0111;
    step(1);
    check_vec("rel.edge10", 32'(bus.stage_rst), 32'h0);
    check_vec("rel.edge10.done", 32'(bus.seq_done), 32'h0);
    step(1);
    bus.stage_ready = 4'b1111;
    check_vec("rel.edge11.done", 32'(bus.seq_done), 32'h0);
    step(1);
    check_all("rel.edge12", 4'b0000, 1'b1, 1'b0, 4'd0);

    // Ready loss in DONE on stage 2.
    bus.stage_ready = 4'b1011;
    step(1);
    check_all("loss", 4'b1111, 1'b0, 1'b1, 4'd2);
    step(2);
    check_all("loss.sticky", 4'b1111, 1'b0, 1'b1, 4'd2);
    rst_req_in      = 1'b1;
    bus.stage_ready = 4'b0000;
    step(1);
    check_all("loss.clear", 4'b1111, 1'b0, 1'b0, 4'd0);
    step(2);

    // Glitch: 3 low, 1 high, then low; release 4 edges after the final fall.
    rst_req_in = 1'b0;
    step(3);
    check_vec("glitch.pre", 32'(bus.stage_rst), 32'hF);
    rst_req_in = 1'b1;
    step(1);
    rst_req_in = 1'b0;
    step(3);
    check_vec("glitch.edge3", 32'(bus.stage_rst), 32'hF);
    step(1);
    check_vec("glitch.edge4", 32'(bus.stage_rst), 32'hE);

    // Timeout on stage 2.
    bus.stage_ready = 4'b0001;
    step(1);
    bus.stage_ready = 4'b0011;
    step(1);
    check_vec("tmo.released2", 32'(bus.stage_rst), 32'h8);
    step(7);
    check_all("tmo.edge7", 4'b1000, 1'b0, 1'b0, 4'd0);
    step(1);
    check_all("tmo.edge8", 4'b1111, 1'b0, 1'b1, 4'd2);
    rst_req_in      = 1'b1;
    bus.stage_ready = 4'b0000;
    step(1);
    check_all("tmo.clear", 4'b1111, 1'b0, 1'b0, 4'd0);

    // Ready arriving on the timeout edge wins.
    rst_req_in = 1'b0;
    step(4);
    check_vec("race.released0", 32'(bus.stage_rst), 32'hE);
    step(7);
    check_vec("race.edge7.err", 32'(bus.seq_error), 32'h0);
    bus.stage_ready = 4'b0001;
    step(1);
    check_all("race.edge8", 4'b1100, 1'b0, 1'b0, 4'd0);

    // Abort while waiting on stage 1, then restart.
    rst_req_in = 1'b1;
    step(1);
    check_all("abort", 4'b1111, 1'b0, 1'b0, 4'd0);
    bus.stage_ready = 4'b0000;
    rst_req_in      = 1'b0;
    step(3);
    check_vec("restart.edge3", 32'(bus.stage_rst), 32'hF);
    step(1);
    check_vec("restart.edge4", 32'(bus.stage_rst), 32'hE);

    // Block reset mid-sequence returns to reset values next edge.
    bus.stage_ready = 4'b0001;
    step(1);
    check_vec("midrst.pre", 32'(bus.stage_rst), 32'hC);
    reset = 1'b1;
    step(1);
    check_all("midrst", 4'b1111, 1'b0, 1'b0, 4'd0);
    reset           = 1'b0;
    bus.stage_ready = 4'b0000;
    step(3);
    check_vec("midrst.edge3", 32'(bus.stage_rst), 32'hF);
    step(1);
    check_vec("midrst.edge4", 32'(bus.stage_rst), 32'hE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
